multicycle_control_unit: RTL and testbench

Main control FSM of the multicycle RV32I core. It decodes the latched instruction's opcode and function fields and sequences the datapath through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, including ImmSrc[2:0], which feeds the immediate extender directly downstream. A MemReady handshake stalls the FSM on slow memory.

---
 rtl/riscv_ctrl_pkg.sv | 75 +++++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 151 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Holds the FSM state enum, ALUOp enum, opcode constants, datapath mux
// encodings, ALUControl codes and two small opcode helper functions.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Immediate format for the extender; it is decoded in every state so the
    // extender output is already valid when DECODE needs the B/J/U offsets.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

    // Only beq/bne are implemented among the branches.
    function automatic logic op_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_IMM,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            OP_BRANCH:                         return (f3[2:1] == 2'b00);
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports: aluop (ADD/SUB/FUNCT request from the FSM), funct3, funct7b5,
//        op5 (Op[5], separates R-type from OP-IMM) -> alucontrol.
module alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_BITS = 4
) (
    input  aluop_t                  aluop,
    input  logic [2:0]              funct3,
    input  logic                    funct7b5,
    input  logic                    op5,
    output logic [ALUCTRL_BITS-1:0] alucontrol
);

    logic [3:0] ctl;

    always_comb begin
        ctl = ALU_ADD;
        case (aluop)
            ALUOP_ADD: ctl = ALU_ADD;
            ALUOP_SUB: ctl = ALU_SUB;
            default: begin
                case (funct3)
                    // addi has no SUB form, so Funct7b5 only matters for R-type
                    3'b000:  ctl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctl = ALU_SLL;
                    3'b010:  ctl = ALU_SLT;
                    3'b011:  ctl = ALU_SLTU;
                    3'b100:  ctl = ALU_XOR;
                    3'b101:  ctl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ctl = ALU_OR;
                    default: ctl = ALU_AND;
                endcase
            end
        endcase
    end

    assign alucontrol = ALUCTRL_BITS'(ctl);

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle RV32I core.
// Inputs:  Clk, ResetN (sync, active low), Op/Funct3/Funct7b5 from the latched
//          instruction, Zero from the ALU, MemReady memory handshake.
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//          ALUSrcB, ImmSrc, ALUControl and a one-cycle IllegalInstr pulse.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_BITS = 4
) (
    input  logic                    Clk,
    input  logic                    ResetN,
    input  logic [6:0]              Op,
    input  logic [2:0]              Funct3,
    input  logic                    Funct7b5,
    input  logic                    Zero,
    input  logic                    MemReady,
    output logic                    PCWrite,
    output logic                    AdrSrc,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    RegWrite,
    output logic [1:0]              ResultSrc,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [2:0]              ImmSrc,
    output logic [ALUCTRL_BITS-1:0] ALUControl,
    output logic                    IllegalInstr
);

    state_t state, next;
    aluop_t aluop;

    always_ff @(posedge Clk) begin
        if (!ResetN) state <= S_FETCH;
        else         state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_FETCH:    if (MemReady) next = S_DECODE;
            S_DECODE: begin
                if (!op_legal(Op, Funct3)) next = S_FETCH;
                else begin
                    case (Op)
                        OP_LOAD, OP_STORE: next = S_MEMADR;
                        OP_R:              next = S_EXECR;
                        OP_IMM, OP_LUI:    next = S_EXECI;
                        OP_BRANCH:         next = S_BRANCH;
                        OP_JAL:            next = S_JAL;
                        OP_JALR:           next = S_JALR;
                        OP_AUIPC:          next = S_ALUWB;  // target already in ALUOut
                        default:           next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   next = Op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) next = S_MEMWB;
            S_MEMWRITE: if (MemReady) next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALRPC: next = S_ALUWB;
            S_JALR:     next = S_JALRPC;
            default:    next = S_FETCH;  // MEMWB, ALUWB, BRANCH
        endcase
    end

    always_comb begin
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_REGB;
        aluop        = ALUOP_ADD;
        IllegalInstr = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_IMM;
                IllegalInstr = !op_legal(Op, Funct3);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_REGA;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                // LUI reuses the OP-IMM path as 0 + imm
                ALUSrcA = (Op == OP_LUI) ? SRCA_ZERO : SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                aluop   = (Op == OP_LUI) ? ALUOP_ADD : ALUOP_FUNCT;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_REGA;
                aluop   = ALUOP_SUB;
                PCWrite = Zero ^ Funct3[0];  // beq takes on equal, bne on not-equal
            end
            S_JALR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
            end
            S_JAL, S_JALRPC: begin
                // PC <- ALUOut (target) while ALU forms the link OldPC+4
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset must suppress every side effect, even mid-instruction.
        if (!ResetN) begin
            PCWrite      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            IllegalInstr = 1'b0;
        end
    end

    assign ImmSrc = imm_src_of(Op);

    alu_decoder #(.ALUCTRL_BITS(ALUCTRL_BITS)) u_alu_dec (
        .aluop      (aluop),
        .funct3     (Funct3),
        .funct7b5   (Funct7b5),
        .op5        (Op[5]),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: an instruction-level model expands each instruction
// into its expected per-cycle control outputs and compares every cycle.
module tb_multicycle_control_unit;

    logic       Clk = 1'b0;
    logic       ResetN;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5, Zero, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    multicycle_control_unit #(.ALUCTRL_BITS(4)) dut (
        .Clk(Clk), .ResetN(ResetN), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .IllegalInstr(IllegalInstr)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] res, a, b;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } ctl_t;

    ctl_t e, m;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                           RI = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;
    logic [6:0] ops [9] = '{LD, ST, RR, RI, BR, JL, JR, LU, AU};

    function automatic logic [2:0] imm_ref(input logic [6:0] op);
        if (op == LD || op == RI || op == JR) return 3'd0;
        if (op == ST) return 3'd1;
        if (op == BR) return 3'd2;
        if (op == LU || op == AU) return 3'd3;
        if (op == JL) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic legal_ref(input logic [6:0] op, input logic [2:0] f3);
        for (int i = 0; i < 9; i++)
            if (ops[i] == op) return (op != BR) || (f3 < 3'd2);
        return 1'b0;
    endfunction

    function automatic logic [3:0] alu_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0: return (op == RR && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd6;
            3'd2: return 4'd5;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd8 : 4'd7;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // Enables, ImmSrc and IllegalInstr are checked every cycle; mux selects
    // only where a value is defined for the phase.
    task automatic begin_ph();
        e = '0; m = '0;
        e.imm = imm_ref(Op);
        m.pcw = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.imm = '1; m.ill = 1'b1;
    endtask
    task automatic set_alu(input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu);
        e.a = a; e.b = b; e.alu = alu; m.a = '1; m.b = '1; m.alu = '1;
    endtask
    task automatic set_res(input logic [1:0] r);
        e.res = r; m.res = '1;
    endtask
    task automatic set_adr(input logic v);
        e.adr = v; m.adr = 1'b1;
    endtask

    task automatic step(input string tag, input logic mr);
        ctl_t obs;
        MemReady = mr;
        #2;
        obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, IllegalInstr};
        n_cmp++;
        assert ((obs & m) === (e & m)) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs & m, e & m);
        end
        @(posedge Clk); #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic ph_aluwb(input string t);
        begin_ph(); set_res(2'b00); e.rw = 1'b1; step({t, "/aluwb"}, rbit());
    endtask
    task automatic ph_link(input string t);
        begin_ph(); set_alu(2'b01, 2'b10, 4'd0); set_res(2'b00); e.pcw = 1'b1;
        step({t, "/pclink"}, rbit());
    endtask

    task automatic run_instr(input string t, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int fst, input int mst);
        Op = op; Funct3 = f3; Funct7b5 = f7; Zero = z;
        for (int i = 0; i <= fst; i++) begin
            begin_ph(); set_alu(2'b00, 2'b10, 4'd0); set_res(2'b10); set_adr(1'b0);
            e.irw = (i == fst); e.pcw = (i == fst);
            step({t, "/fetch"}, i == fst);
        end
        begin_ph(); set_alu(2'b01, 2'b01, 4'd0); e.ill = !legal_ref(op, f3);
        step({t, "/decode"}, rbit());
        if (!legal_ref(op, f3)) return;
        if (op == LD || op == ST) begin
            begin_ph(); set_alu(2'b10, 2'b01, 4'd0); step({t, "/memadr"}, rbit());
            for (int i = 0; i <= mst; i++) begin
                begin_ph(); set_res(2'b00); set_adr(1'b1); e.mw = (op == ST);
                step({t, "/memacc"}, i == mst);
            end
            if (op == LD) begin
                begin_ph(); set_res(2'b01); e.rw = 1'b1; step({t, "/memwb"}, rbit());
            end
        end else if (op == RR || op == RI) begin
            begin_ph(); set_alu(2'b10, (op == RR) ? 2'b00 : 2'b01, alu_ref(op, f3, f7));
            step({t, "/exec"}, rbit());
            ph_aluwb(t);
        end else if (op == LU) begin
            begin_ph(); set_alu(2'b11, 2'b01, 4'd0); step({t, "/lui"}, rbit());
            ph_aluwb(t);
        end else if (op == AU) begin
            ph_aluwb(t);
        end else if (op == BR) begin
            begin_ph(); set_alu(2'b10, 2'b00, 4'd1); set_res(2'b00); e.pcw = z ^ f3[0];
            step({t, "/branch"}, rbit());
        end else if (op == JL) begin
            ph_link(t); ph_aluwb(t);
        end else begin
            begin_ph(); set_alu(2'b10, 2'b01, 4'd0); step({t, "/jalr"}, rbit());
            ph_link(t); ph_aluwb(t);
        end
    endtask

    initial begin
        ResetN = 1'b0; Op = ST; Funct3 = 3'd0; Funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
        begin_ph(); step("reset0", 1'b1);
        begin_ph(); step("reset1", 1'b1);
        ResetN = 1'b1;

        run_instr("lw",    LD, 3'd2, 1'b0, 1'b0, 0, 3);
        run_instr("sw",    ST, 3'd2, 1'b0, 1'b0, 1, 2);
        run_instr("beq_t", BR, 3'd0, 1'b0, 1'b1, 0, 0);
        run_instr("beq_n", BR, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("bne_z", BR, 3'd1, 1'b0, 1'b1, 0, 0);
        run_instr("blt",   BR, 3'd4, 1'b0, 1'b1, 0, 0);
        run_instr("sub",   RR, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr("srai",  RI, 3'd5, 1'b1, 1'b0, 0, 0);
        run_instr("addi",  RI, 3'd0, 1'b1, 1'b0, 0, 0);
        run_instr("jal",   JL, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("jalr",  JR, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("lui",   LU, 3'd3, 1'b0, 1'b0, 0, 0);
        run_instr("auipc", AU, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr("illeg", 7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);

        // Abort a store while MEMWRITE is waiting on memory.
        Op = ST; Funct3 = 3'd2; Funct7b5 = 1'b0; Zero = 1'b0;
        begin_ph(); set_alu(2'b00, 2'b10, 4'd0); e.irw = 1'b1; e.pcw = 1'b1;
        step("abort/fetch", 1'b1);
        begin_ph(); step("abort/decode", 1'b0);
        begin_ph(); set_alu(2'b10, 2'b01, 4'd0); step("abort/memadr", 1'b0);
        begin_ph(); set_adr(1'b1); e.mw = 1'b1; step("abort/memwrite", 1'b0);
        ResetN = 1'b0;
        begin_ph(); step("abort/reset", 1'b0);
        ResetN = 1'b1;
        run_instr("after_abort", RR, 3'd7, 1'b0, 1'b0, 0, 0);

        for (int k = 0; k < 200; k++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            run_instr($sformatf("rnd%0d", k), op, 3'($urandom), rbit(), rbit(),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
